// File: rtl/musa_pkg.sv
// Shared definitions for the pipeline blocks: PC width, stack depth default,
// and the {push,pop} stack operation encoding.
package musa_pkg;
  localparam int PC_W      = 32;
  localparam int RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;
endpackage

// File: rtl/call_stack_mem.sv
// Return-address storage: DEPTH x ADDR_W registers, one synchronous write
// port and one asynchronous read port, deliberately without reset.
module call_stack_mem
  import musa_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH,
  parameter int ADDR_W = PC_W,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  // Entry write on a committed push or replace.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack: commits one push/pop/replace per rising
// edge of aux_push_pop and presents the registered top of stack on ret_addr.
module call_stack
  import musa_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH,
  parameter int ADDR_W = PC_W,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              aux_push_pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] ret_addr,
  output logic [CNT_W-1:0]  depth,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = $clog2(DEPTH);

  logic              aux_q;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic [ADDR_W-1:0] ret_q, ret_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              commit_s;
  logic              full_s;
  logic              empty_s;
  stack_op_e         op_s;
  logic              we_s;
  logic [IDX_W-1:0]  waddr_s;
  logic [IDX_W-1:0]  raddr_s;
  logic [ADDR_W-1:0] rdata_s;

  assign commit_s = aux_push_pop & ~aux_q;
  assign op_s     = stack_op_e'({push, pop});
  assign full_s   = (depth_q == CNT_W'(DEPTH));
  assign empty_s  = (depth_q == {CNT_W{1'b0}});
  // Entry below the current top; only consumed on a pop with depth >= 2.
  assign raddr_s  = IDX_W'(depth_q - CNT_W'(2));

  call_stack_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (push_addr),
    .raddr_i (raddr_s),
    .rdata_o (rdata_s)
  );

  // Next-state selection for pointer, top-of-stack and sticky flags.
  always_comb begin
    depth_d = depth_q;
    ret_d   = ret_q;
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;
    we_s    = 1'b0;
    waddr_s = IDX_W'(depth_q);
    if (commit_s) begin
      case (op_s)
        OP_PUSH: begin
          if (!full_s) begin
            we_s    = 1'b1;
            depth_d = depth_q + CNT_W'(1);
            ret_d   = push_addr;
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_POP: begin
          if (!empty_s) begin
            depth_d = depth_q - CNT_W'(1);
            if (depth_q == CNT_W'(1)) begin
              ret_d = {ADDR_W{1'b0}};
            end else begin
              ret_d = rdata_s;
            end
          end else begin
            unf_d = 1'b1;
          end
        end
        OP_REPL: begin
          we_s  = 1'b1;
          ret_d = push_addr;
          if (!empty_s) begin
            waddr_s = IDX_W'(depth_q - CNT_W'(1));
          end else begin
            depth_d = CNT_W'(1);
          end
        end
        OP_NONE: begin
          depth_d = depth_q;
        end
        default: begin
          depth_d = depth_q;
        end
      endcase
    end else begin
      we_s = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset; entries are not cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aux_q   <= 1'b0;
      depth_q <= {CNT_W{1'b0}};
      ret_q   <= {ADDR_W{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      aux_q   <= aux_push_pop;
      depth_q <= depth_d;
      ret_q   <= ret_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign ret_addr  = ret_q;
  assign depth     = depth_q;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios plus random ops,
// compared every cycle against an array-based stack model.
module tb_call_stack;
  import musa_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          aux = 1'b0;
  logic          clr = 1'b0;
  logic [AW-1:0] paddr = 32'h0;
  logic [AW-1:0] ret_addr;
  logic [CW-1:0] depth;
  logic          empty, full, overflow, underflow;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  call_stack #(.DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .aux_push_pop (aux),
    .push_addr    (paddr),
    .clr_err      (clr),
    .ret_addr     (ret_addr),
    .depth        (depth),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Reference model: a plain array stack with a count and two sticky flags.
  logic [AW-1:0] m_stack [DEPTH];
  int            m_depth;
  bit            m_ovf, m_unf, m_aux_prev;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_depth    <= 0;
      m_ovf      <= 1'b0;
      m_unf      <= 1'b0;
      m_aux_prev <= 1'b0;
    end else begin
      m_aux_prev <= aux;
      if (clr) begin
        m_ovf <= 1'b0;
        m_unf <= 1'b0;
      end
      if (aux && !m_aux_prev) begin
        if (push && pop && m_depth > 0) begin
          m_stack[m_depth-1] <= paddr;
        end else if (push) begin
          if (m_depth < DEPTH) begin
            m_stack[m_depth] <= paddr;
            m_depth          <= m_depth + 1;
          end else begin
            m_ovf <= 1'b1;
          end
        end else if (pop) begin
          if (m_depth > 0) m_depth <= m_depth - 1;
          else             m_unf   <= 1'b1;
        end
      end
    end
  end

  function automatic logic [AW-1:0] m_top();
    return (m_depth == 0) ? 32'h0 : m_stack[m_depth-1];
  endfunction

  task automatic cmp(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en && reset) begin
      cmp("ret_addr", ret_addr, m_top());
      cmp("depth", 32'(depth), 32'(m_depth));
      cmp("empty", 32'(empty), 32'(m_depth == 0));
      cmp("full", 32'(full), 32'(m_depth == DEPTH));
      cmp("overflow", 32'(overflow), 32'(m_ovf));
      cmp("underflow", 32'(underflow), 32'(m_unf));
    end
  end

  // One instruction: strobe high for 'hold' cycles, optional clr_err in the first.
  task automatic do_op(bit p, bit q, logic [AW-1:0] a, int hold, bit c);
    @(negedge clk);
    push = p; pop = q; paddr = a; aux = 1'b1; clr = c;
    @(negedge clk);
    clr = 1'b0;
    repeat (hold - 1) @(negedge clk);
    aux = 1'b0; push = 1'b0; pop = 1'b0;
    @(negedge clk);
  endtask

  task automatic lit_state(string tag, logic [AW-1:0] r, int d, bit o, bit u);
    cmp({tag, ".ret"}, ret_addr, r);
    cmp({tag, ".depth"}, 32'(depth), 32'(d));
    cmp({tag, ".empty"}, 32'(empty), 32'(d == 0));
    cmp({tag, ".full"}, 32'(full), 32'(d == DEPTH));
    cmp({tag, ".ovf"}, 32'(overflow), 32'(o));
    cmp({tag, ".unf"}, 32'(underflow), 32'(u));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    lit_state("reset", 32'h0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    check_en = 1'b1;

    // push level without a strobe must not commit
    push = 1'b1; paddr = 32'h55;
    repeat (3) @(negedge clk);
    push = 1'b0;
    @(negedge clk);
    lit_state("nostrobe", 32'h0, 0, 1'b0, 1'b0);

    do_op(1'b1, 1'b0, 32'h10, 1, 1'b0);
    do_op(1'b1, 1'b0, 32'h20, 1, 1'b0);
    do_op(1'b1, 1'b0, 32'h30, 1, 1'b0);
    lit_state("call3", 32'h30, 3, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'h0, 1, 1'b0);
    cmp("ret1", ret_addr, 32'h20);
    do_op(1'b0, 1'b1, 32'h0, 1, 1'b0);
    cmp("ret2", ret_addr, 32'h10);
    do_op(1'b0, 1'b1, 32'h0, 1, 1'b0);
    lit_state("ret3", 32'h0, 0, 1'b0, 1'b0);

    do_op(1'b1, 1'b0, 32'hAA, 5, 1'b0);
    lit_state("hold5", 32'hAA, 1, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'h0, 1, 1'b0);

    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 32'h100 + 32'(i), 1, 1'b0);
    do_op(1'b1, 1'b0, 32'h200, 1, 1'b0);
    lit_state("ovf", 32'h107, 8, 1'b1, 1'b0);
    do_op(1'b0, 1'b1, 32'h0, 1, 1'b0);
    lit_state("ovfpop", 32'h106, 7, 1'b1, 1'b0);
    do_op(1'b0, 1'b0, 32'h0, 1, 1'b1);
    cmp("ovfclr", 32'(overflow), 32'h0);
    for (int i = 0; i < 7; i++) do_op(1'b0, 1'b1, 32'h0, 1, 1'b0);

    do_op(1'b0, 1'b1, 32'h0, 1, 1'b0);
    lit_state("unf", 32'h0, 0, 1'b0, 1'b1);
    do_op(1'b0, 1'b1, 32'h0, 1, 1'b1);
    cmp("unfwin", 32'(underflow), 32'h1);
    do_op(1'b0, 1'b0, 32'h0, 1, 1'b1);
    cmp("unfclr", 32'(underflow), 32'h0);

    do_op(1'b1, 1'b0, 32'h40, 1, 1'b0);
    do_op(1'b1, 1'b0, 32'h50, 1, 1'b0);
    do_op(1'b1, 1'b1, 32'h99, 1, 1'b0);
    lit_state("repl", 32'h99, 2, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'h0, 1, 1'b0);
    lit_state("replpop", 32'h40, 1, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'h0, 1, 1'b0);

    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 32'h300 + 32'(i), 1, 1'b0);
    cmp("mid5", 32'(depth), 32'h5);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 lit_state("asyncrst", 32'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 400; i++) begin
      do_op(($urandom % 3) != 0, ($urandom % 2) == 1, $urandom,
            int'($urandom_range(1, 3)), ($urandom % 8) == 0);
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
